// File: rtl/mcht_tx_feeder.sv
// Feeds host words from a small circular FIFO to a Manchester transceiver,
// one launch at a time, with a post-completion gap and a completion timeout.
module mcht_tx_feeder #(
  parameter int pMSG_LEN = 8,
  parameter int pDEPTH   = 4,
  parameter int pGAP     = 2,
  parameter int pTMO     = 255
) (
  input  logic                    CLK_25M,
  input  logic                    RST,
  input  logic                    IN_VLD,
  input  logic [pMSG_LEN-1:0]     IN_MSG,
  output logic                    IN_RDY,
  input  logic                    HALT,
  output logic                    TX_VLD,
  output logic [pMSG_LEN-1:0]     TX_MSG,
  input  logic                    TX_DNE,
  output logic [$clog2(pDEPTH):0] LVL,
  output logic                    BUSY,
  output logic                    OVF,
  output logic                    TMO
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(pTMO + 1);
  localparam int GW = (pGAP > 1) ? $clog2(pGAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       lvl_q, lvl_d;
  logic                tx_vld_q, tx_vld_d;
  logic [pMSG_LEN-1:0] tx_msg_q, tx_msg_d;
  logic                ovf_q, ovf_d;
  logic                tmo_q, tmo_d;
  logic [TW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;

  logic [pMSG_LEN-1:0] mem [pDEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  always_comb begin
    full  = (lvl_q == LW'(pDEPTH));
    empty = (lvl_q == '0);
    push  = IN_VLD & ~full;
    // HALT only gates the decision made in IDLE; in-flight words finish normally.
    pop   = (state_q == S_IDLE) & ~empty & ~HALT;

    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    lvl_d      = lvl_q;
    tx_vld_d   = 1'b0;
    tx_msg_d   = tx_msg_q;
    ovf_d      = ovf_q | (IN_VLD & full);
    tmo_d      = tmo_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      tx_msg_d = mem[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d  = S_LAUNCH;
          tx_vld_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (TX_DNE) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else if (wait_cnt_q == TW'(pTMO - 1)) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
          tmo_d     = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(pGAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_25M) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lvl_q      <= '0;
      tx_vld_q   <= 1'b0;
      tx_msg_q   <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      lvl_q      <= lvl_d;
      tx_vld_q   <= tx_vld_d;
      tx_msg_q   <= tx_msg_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Storage has no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge CLK_25M) begin
    if (push) begin
      mem[wr_ptr_q] <= IN_MSG;
    end
  end

  assign IN_RDY = ~full;
  assign TX_VLD = tx_vld_q;
  assign TX_MSG = tx_msg_q;
  assign LVL    = lvl_q;
  assign BUSY   = (state_q != S_IDLE);
  assign OVF    = ovf_q;
  assign TMO    = tmo_q;

endmodule

// File: tb/tb_mcht_tx_feeder.sv
// Self-checking bench for mcht_tx_feeder: directed scenarios plus a randomized
// run scored against a schedule-level model of the launch timing.
`timescale 1ns/1ps
module tb_mcht_tx_feeder;
  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam int GAP = 2;
  localparam int TMO_CYC = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_vld = 1'b0;
  logic [W-1:0] in_msg = '0;
  logic         in_rdy;
  logic         halt = 1'b0;
  logic         tx_vld;
  logic [W-1:0] tx_msg;
  logic         tx_dne = 1'b0;
  logic [2:0]   lvl;
  logic         busy;
  logic         ovf;
  logic         tmo;

  int n_checks = 0;
  int n_fails = 0;

  mcht_tx_feeder #(.pMSG_LEN(W), .pDEPTH(DEPTH), .pGAP(GAP), .pTMO(TMO_CYC)) dut (
    .CLK_25M(clk), .RST(rst), .IN_VLD(in_vld), .IN_MSG(in_msg), .IN_RDY(in_rdy),
    .HALT(halt), .TX_VLD(tx_vld), .TX_MSG(tx_msg), .TX_DNE(tx_dne), .LVL(lvl),
    .BUSY(busy), .OVF(ovf), .TMO(tmo)
  );

  always #20 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0; halt = 1'b0; tx_dne = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) until TX_VLD is seen; cycles = ticks spent waiting.
  task automatic wait_launch(input int limit, output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i <= limit; i++) begin
      cycles = i;
      if (tx_vld === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Called in WAIT cycle 1; asserts TX_DNE in WAIT cycle d, returns in GAP cycle 1.
  task automatic finish_tx(input int d);
    repeat (d - 1) tick();
    tx_dne = 1'b1;
    tick();
    tx_dne = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++; if (lvl !== 3'd0) begin n_fails++; $display("FAIL reset_lvl: got %0d expected 0", lvl); end
    n_checks++; if (tx_vld !== 1'b0) begin n_fails++; $display("FAIL reset_tx_vld: got %b expected 0", tx_vld); end
    n_checks++; if (tx_msg !== 8'h00) begin n_fails++; $display("FAIL reset_tx_msg: got %0h expected 0", tx_msg); end
    n_checks++; if (ovf !== 1'b0) begin n_fails++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if (tmo !== 1'b0) begin n_fails++; $display("FAIL reset_tmo: got %b expected 0", tmo); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_rdy !== 1'b1) begin n_fails++; $display("FAIL reset_in_rdy: got %b expected 1", in_rdy); end
    rst = 1'b0;
    // Reset landing on the edge that would have launched a queued word.
    halt = 1'b1;
    in_vld = 1'b1; in_msg = 8'h5A; tick();
    in_msg = 8'h6B; tick();
    in_vld = 1'b0; halt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (tx_vld !== 1'b0) begin n_fails++; $display("FAIL reset_launch_edge_tx_vld: got %b expected 0", tx_vld); end
    n_checks++; if (lvl !== 3'd0) begin n_fails++; $display("FAIL reset_launch_edge_lvl: got %0d expected 0", lvl); end
  endtask

  task automatic test_single_word();
    do_reset();
    in_vld = 1'b1; in_msg = 8'hA5;
    tick();
    in_vld = 1'b0;
    n_checks++; if (lvl !== 3'd1) begin n_fails++; $display("FAIL single_lvl_after_push: got %0d expected 1", lvl); end
    n_checks++; if (tx_vld !== 1'b0) begin n_fails++; $display("FAIL single_early_tx_vld: got %b expected 0", tx_vld); end
    tick();
    n_checks++; if (tx_vld !== 1'b1) begin n_fails++; $display("FAIL single_tx_vld: got %b expected 1", tx_vld); end
    n_checks++; if (tx_msg !== 8'hA5) begin n_fails++; $display("FAIL single_tx_msg: got %0h expected a5", tx_msg); end
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL single_busy_launch: got %b expected 1", busy); end
    tick();
    n_checks++; if (tx_vld !== 1'b0) begin n_fails++; $display("FAIL single_pulse_width: got %b expected 0", tx_vld); end
    finish_tx(40);
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL single_gap1_busy: got %b expected 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL single_gap2_busy: got %b expected 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    n_checks++; if (tx_msg !== 8'hA5) begin n_fails++; $display("FAIL single_msg_hold: got %0h expected a5", tx_msg); end
    n_checks++; if (tmo !== 1'b0) begin n_fails++; $display("FAIL single_tmo: got %b expected 0", tmo); end
  endtask

  task automatic test_fill_overflow();
    int c;
    bit seen;
    do_reset();
    halt = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_vld = 1'b1; in_msg = W'(i);
      tick();
      n_checks++; if (lvl !== 3'((i > DEPTH) ? DEPTH : i)) begin n_fails++; $display("FAIL fill_lvl[%0d]: got %0d expected %0d", i, lvl, (i > DEPTH) ? DEPTH : i); end
      n_checks++; if (ovf !== (i == 5)) begin n_fails++; $display("FAIL fill_ovf[%0d]: got %b expected %b", i, ovf, i == 5); end
    end
    in_vld = 1'b0;
    n_checks++; if (in_rdy !== 1'b0) begin n_fails++; $display("FAIL fill_in_rdy: got %b expected 0", in_rdy); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL fill_halt_busy: got %b expected 0", busy); end
    halt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      wait_launch(10, c, seen);
      n_checks++; if (!seen) begin n_fails++; $display("FAIL fill_launch_seen[%0d]: got none expected launch", k); end
      n_checks++; if (tx_msg !== W'(k)) begin n_fails++; $display("FAIL fill_order[%0d]: got %0h expected %0h", k, tx_msg, k); end
      n_checks++; if (c != ((k == 1) ? 1 : GAP + 1)) begin n_fails++; $display("FAIL fill_period[%0d]: got %0d expected %0d", k, c, (k == 1) ? 1 : GAP + 1); end
      tick();
      finish_tx($urandom_range(1, 20));
    end
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || lvl !== 3'd0) begin n_fails++; $display("FAIL fill_drained: got busy=%b lvl=%0d expected busy=0 lvl=0", busy, lvl); end
    n_checks++; if (ovf !== 1'b1) begin n_fails++; $display("FAIL fill_ovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_push_pop();
    logic [W-1:0] w [9];
    int c;
    bit seen;
    int exp_lvl;
    do_reset();
    for (int j = 0; j < 9; j++) w[j] = W'($urandom_range(0, 255));
    halt = 1'b1;
    in_vld = 1'b1; in_msg = w[0]; tick();
    in_msg = w[1]; tick();
    in_vld = 1'b0;
    n_checks++; if (lvl !== 3'd2) begin n_fails++; $display("FAIL pp_pre_lvl: got %0d expected 2", lvl); end
    halt = 1'b0; in_vld = 1'b1; in_msg = w[2];
    tick();
    in_vld = 1'b0;
    n_checks++; if (tx_vld !== 1'b1) begin n_fails++; $display("FAIL pp_launch: got %b expected 1", tx_vld); end
    for (int j = 0; j < 9; j++) begin
      if (j > 0) begin
        wait_launch(10, c, seen);
        n_checks++; if (!seen || c != GAP + 1) begin n_fails++; $display("FAIL pp_period[%0d]: got seen=%b cycles=%0d expected cycles=%0d", j, seen, c, GAP + 1); end
      end
      exp_lvl = ((j + 2 > 8) ? 8 : j + 2) - j;
      n_checks++; if (tx_msg !== w[j]) begin n_fails++; $display("FAIL pp_msg[%0d]: got %0h expected %0h", j, tx_msg, w[j]); end
      n_checks++; if (lvl !== 3'(exp_lvl)) begin n_fails++; $display("FAIL pp_lvl[%0d]: got %0d expected %0d", j, lvl, exp_lvl); end
      if (j + 3 <= 8) begin
        in_vld = 1'b1; in_msg = w[j + 3];
      end
      tick();
      in_vld = 1'b0;
      finish_tx($urandom_range(1, 8));
    end
    tick(); tick();
    n_checks++; if (busy !== 1'b0 || lvl !== 3'd0) begin n_fails++; $display("FAIL pp_end: got busy=%b lvl=%0d expected busy=0 lvl=0", busy, lvl); end
  endtask

  task automatic test_timeout();
    int c;
    bit seen;
    do_reset();
    halt = 1'b1;
    in_vld = 1'b1; in_msg = 8'hC1; tick();
    in_msg = 8'hC2; tick();
    in_vld = 1'b0; halt = 1'b0;
    wait_launch(5, c, seen);
    n_checks++; if (!seen || tx_msg !== 8'hC1) begin n_fails++; $display("FAIL tmo_first: got seen=%b msg=%0h expected c1", seen, tx_msg); end
    repeat (TMO_CYC) tick();
    n_checks++; if (tmo !== 1'b0) begin n_fails++; $display("FAIL tmo_early: got %b expected 0", tmo); end
    tick();
    n_checks++; if (tmo !== 1'b1) begin n_fails++; $display("FAIL tmo_set: got %b expected 1", tmo); end
    n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL tmo_gap_busy: got %b expected 1", busy); end
    wait_launch(10, c, seen);
    n_checks++; if (!seen || c != GAP + 1) begin n_fails++; $display("FAIL tmo_next_launch: got seen=%b cycles=%0d expected %0d", seen, c, GAP + 1); end
    n_checks++; if (tx_msg !== 8'hC2) begin n_fails++; $display("FAIL tmo_next_msg: got %0h expected c2", tx_msg); end
    tick();
    finish_tx(4);
    n_checks++; if (tmo !== 1'b1) begin n_fails++; $display("FAIL tmo_sticky: got %b expected 1", tmo); end
    tick(); tick();
  endtask

  task automatic test_spurious_done();
    do_reset();
    tx_dne = 1'b1; tick(); tx_dne = 1'b0;
    n_checks++; if (busy !== 1'b0 || tx_vld !== 1'b0) begin n_fails++; $display("FAIL spur_idle_empty: got busy=%b tx_vld=%b expected 0 0", busy, tx_vld); end
    halt = 1'b1; in_vld = 1'b1; in_msg = 8'h3C; tick(); in_vld = 1'b0;
    tx_dne = 1'b1; tick(); tx_dne = 1'b0;
    n_checks++; if (busy !== 1'b0 || tx_vld !== 1'b0 || lvl !== 3'd1) begin n_fails++; $display("FAIL spur_idle_halted: got busy=%b tx_vld=%b lvl=%0d expected 0 0 1", busy, tx_vld, lvl); end
    halt = 1'b0;
    tick();
    n_checks++; if (tx_vld !== 1'b1 || tx_msg !== 8'h3C) begin n_fails++; $display("FAIL spur_launch: got tx_vld=%b msg=%0h expected 1 3c", tx_vld, tx_msg); end
    tick();
    finish_tx(5);
    tx_dne = 1'b1; in_vld = 1'b1; in_msg = 8'h77;
    tick();
    tx_dne = 1'b0; in_vld = 1'b0;
    n_checks++; if (busy !== 1'b1 || tx_vld !== 1'b0 || lvl !== 3'd1) begin n_fails++; $display("FAIL spur_gap: got busy=%b tx_vld=%b lvl=%0d expected 1 0 1", busy, tx_vld, lvl); end
    tick();
    n_checks++; if (busy !== 1'b0 || tx_vld !== 1'b0) begin n_fails++; $display("FAIL spur_idle_after_gap: got busy=%b tx_vld=%b expected 0 0", busy, tx_vld); end
    tick();
    n_checks++; if (tx_vld !== 1'b1 || tx_msg !== 8'h77) begin n_fails++; $display("FAIL spur_next_launch: got tx_vld=%b msg=%0h expected 1 77", tx_vld, tx_msg); end
    tick();
    finish_tx(3);
    tick(); tick();
  endtask

  task automatic test_reset_in_wait();
    int launches;
    do_reset();
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_msg = W'(8'h10 + i); tick();
    end
    in_vld = 1'b0; halt = 1'b0;
    tick(); tick();
    n_checks++; if (lvl !== 3'd3 || busy !== 1'b1 || ovf !== 1'b1) begin n_fails++; $display("FAIL rw_pre: got lvl=%0d busy=%b ovf=%b expected 3 1 1", lvl, busy, ovf); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (lvl !== 3'd0) begin n_fails++; $display("FAIL rw_lvl: got %0d expected 0", lvl); end
    n_checks++; if (tx_vld !== 1'b0) begin n_fails++; $display("FAIL rw_tx_vld: got %b expected 0", tx_vld); end
    n_checks++; if (ovf !== 1'b0 || tmo !== 1'b0) begin n_fails++; $display("FAIL rw_flags: got ovf=%b tmo=%b expected 0 0", ovf, tmo); end
    n_checks++; if (busy !== 1'b0 || in_rdy !== 1'b1) begin n_fails++; $display("FAIL rw_busy_rdy: got busy=%b in_rdy=%b expected 0 1", busy, in_rdy); end
    launches = 0;
    for (int i = 0; i < 30; i++) begin
      tx_dne = (i == 3);
      tick();
      if (tx_vld === 1'b1 || busy === 1'b1) launches++;
    end
    tx_dne = 1'b0;
    n_checks++; if (launches != 0 || lvl !== 3'd0) begin n_fails++; $display("FAIL rw_no_launch: got launches=%0d lvl=%0d expected 0 0", launches, lvl); end
  endtask

  // Model: queue of accepted words; each launch is scheduled arithmetically as
  // IDLE decision -> 1 LAUNCH cycle -> d WAIT cycles -> GAP cycles -> IDLE.
  task automatic test_random();
    logic [W-1:0] q [$];
    logic [W-1:0] last_msg;
    logic [W-1:0] m;
    int idle_from, launch_n, wait_end, d;
    bit v, h, dn, full, ovf_m;
    do_reset();
    idle_from = 0; launch_n = -1; wait_end = -1; last_msg = '0; ovf_m = 1'b0;
    for (int n = 0; n < 600; n++) begin
      n_checks++; if (tx_vld !== (n == launch_n)) begin n_fails++; $display("FAIL rnd_tx_vld@%0d: got %b expected %b", n, tx_vld, n == launch_n); end
      n_checks++; if (lvl !== 3'(q.size())) begin n_fails++; $display("FAIL rnd_lvl@%0d: got %0d expected %0d", n, lvl, q.size()); end
      n_checks++; if (busy !== (n < idle_from)) begin n_fails++; $display("FAIL rnd_busy@%0d: got %b expected %b", n, busy, n < idle_from); end
      n_checks++; if (tx_msg !== last_msg) begin n_fails++; $display("FAIL rnd_tx_msg@%0d: got %0h expected %0h", n, tx_msg, last_msg); end
      n_checks++; if (ovf !== ovf_m || in_rdy !== (q.size() != DEPTH)) begin n_fails++; $display("FAIL rnd_ovf_rdy@%0d: got ovf=%b rdy=%b expected %b %b", n, ovf, in_rdy, ovf_m, q.size() != DEPTH); end
      v = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 5) == 0);
      m = W'($urandom_range(0, 255));
      dn = (n == wait_end) || (!(n > launch_n && n <= wait_end) && ($urandom_range(0, 5) == 0));
      full = (q.size() == DEPTH);
      if (v && full) ovf_m = 1'b1;
      if (n >= idle_from && q.size() > 0 && !h) begin
        last_msg = q.pop_front();
        d = $urandom_range(1, 12);
        launch_n = n + 1;
        wait_end = n + 1 + d;
        idle_from = n + 2 + d + GAP;
      end
      if (v && !full) q.push_back(m);
      in_vld = v; in_msg = m; halt = h; tx_dne = dn;
      tick();
    end
    in_vld = 1'b0; halt = 1'b0; tx_dne = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_push_pop();
    test_timeout();
    test_spurious_done();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mcht_tx_feeder.md
MCHT_TX_FEEDER -- requirements
Module: mcht_tx_feeder

Interface
REQ-001 The block SHALL have parameter pMSG_LEN, default 8: width of one message word.
REQ-002 The block SHALL have parameter pDEPTH, default 4: FIFO depth in words, a power of 2, at least 2.
REQ-003 The block SHALL have parameter pGAP, default 2: idle cycles between TX_DNE and the next launch, at least 1.
REQ-004 The block SHALL have parameter pTMO, default 255: maximum cycles to wait for TX_DNE after a launch.
REQ-005 The block SHALL have port CLK_25M  in  1: sole clock, rising edge. One clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port RST  in  1: synchronous active-high reset.
REQ-007 The block SHALL have port IN_VLD  in  1: host offers a word this cycle.
REQ-008 The block SHALL have port IN_MSG  in  pMSG_LEN: host word.
REQ-009 The block SHALL have port IN_RDY  out  1: FIFO not full; a word is pushed when IN_VLD & IN_RDY.
REQ-010 The block SHALL have port HALT  in  1: when high, no new launch starts.
REQ-011 The block SHALL have port TX_VLD  out  1: one-cycle launch pulse to the Manchester transceiver.
REQ-012 The block SHALL have port TX_MSG  out  pMSG_LEN: word under transmission.
REQ-013 The block SHALL have port TX_DNE  in  1: transceiver completion pulse.
REQ-014 The block SHALL have port LVL  out  log2(pDEPTH)+1: FIFO occupancy.
REQ-015 The block SHALL have port BUSY  out  1: FSM not in IDLE.
REQ-016 The block SHALL have port OVF  out  1: sticky flag, set when a push is attempted while full.
REQ-017 The block SHALL have port TMO  out  1: sticky flag, set on a TX_DNE timeout.

Function
REQ-018 The FIFO SHALL be circular with rd/wr pointers of log2(pDEPTH) bits that wrap from pDEPTH-1 to 0; LVL SHALL count 0..pDEPTH.
REQ-019 IN_RDY SHALL equal (LVL != pDEPTH), computed from registered state only.
REQ-020 IN_VLD while full SHALL drop the word, leave the FIFO unchanged and set OVF.
REQ-021 A push and a pop in the same cycle SHALL both take effect, with LVL unchanged; this is legal only when not full.
REQ-022 The FSM SHALL have states IDLE, LAUNCH, WAIT, GAP.
REQ-023 IDLE SHALL go to LAUNCH when LVL != 0 and HALT is low; otherwise it SHALL stay in IDLE.
REQ-024 The IDLE->LAUNCH edge SHALL load TX_MSG from the FIFO head and pop it.
REQ-025 LAUNCH SHALL last exactly one cycle with TX_VLD=1, then go to WAIT; TX_VLD SHALL be 0 in every other state.
REQ-026 WAIT SHALL go to GAP on TX_DNE.
REQ-027 WAIT SHALL go to GAP and set TMO when its cycle counter reaches pTMO without TX_DNE; the counter SHALL be cleared on entry to WAIT.
REQ-028 GAP SHALL last exactly pGAP cycles, then go to IDLE.
REQ-029 TX_DNE outside WAIT SHALL be ignored.
REQ-030 TX_MSG SHALL be held constant from LAUNCH until the next launch.
REQ-031 HALT SHALL be sampled only in IDLE; a word already launched SHALL complete normally.
REQ-032 Latency: with the block in IDLE and the FIFO empty, a push at edge E SHALL make LVL=1 after E, and TX_VLD SHALL be high in the cycle following edge E+1.
REQ-033 A back-to-back launch period SHALL be 1 (LAUNCH) + WAIT length + pGAP + 1 (IDLE) cycles.
REQ-034 BUSY SHALL equal (state != IDLE).
REQ-035 OVF and TMO SHALL clear only on RST.

Reset
REQ-036 RST high at a clock edge SHALL set the state to IDLE and clear the pointers, LVL=0, TX_VLD=0, TX_MSG=0, OVF=0, TMO=0, BUSY=0, with IN_RDY=1 on the following cycle.
REQ-037 RST mid-operation (any state, FIFO non-empty) SHALL discard all queued words and any launch in flight, with no TX_VLD pulse in the reset cycle.
REQ-038 After RST is released, the first TX_DNE SHALL be ignored unless the block is in WAIT.

Verification
REQ-039 Verification SHALL cover a single word: push 0xA5 into an idle, empty block -> TX_VLD one-cycle pulse with TX_MSG=0xA5 two edges later; TX_DNE 40 cycles later -> GAP 2 cycles -> BUSY=0.
REQ-040 Verification SHALL cover fill and overflow: push 0x01..0x05 with HALT=1 -> LVL=4, IN_RDY=0, 0x05 dropped, OVF=1; release HALT -> launches 0x01,0x02,0x03,0x04 in order, each after a TX_DNE.
REQ-041 Verification SHALL cover push and pop together: LVL=2 and a push on the IDLE->LAUNCH edge -> LVL stays 2, and the pointers wrap correctly after 9 words.
REQ-042 Verification SHALL cover timeout: no TX_DNE after a launch -> TMO=1 after 255 WAIT cycles, then GAP, then the next queued word launches.
REQ-043 Verification SHALL cover a spurious done: TX_DNE pulsed in IDLE and in GAP -> no state change and no premature launch.
REQ-044 Verification SHALL cover reset in WAIT with LVL=3: RST for 1 cycle -> LVL=0, TX_VLD=0, OVF=TMO=0, and no further launches without new pushes.
